bram_fifo_reader: RTL and testbench

Read-side controller for the dual-port BRAM FIFO used between SNN pipeline stages. The FIFO has only free-running read and write pointers and no flags. This block shadows the writer's push strobe to track occupancy, and issues `fifo_rden` only when the FIFO holds data. It absorbs the one-cycle BRAM read latency in a 2-entry output buffer and presents the data as a valid/ready stream at full throughput.

---
 rtl/bram_fifo_reader_if.sv | 21 ++
 rtl/bram_fifo_reader.sv | 140 ++++++++++++++
 tb/tb_bram_fifo_reader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_fifo_reader_if.sv
// ----------------------------------------------------------------------------
// bram_fifo_reader_if
//   Valid/ready stream carrying words out of the BRAM FIFO read controller.
//
//   m_data   : head word of the reader's output buffer
//   m_valid  : m_data holds a word
//   m_ready  : consumer accepts; a word moves when m_valid && m_ready
//
//   master : the reader (drives data/valid)
//   slave  : the consumer (drives ready)
// ----------------------------------------------------------------------------
interface bram_fifo_reader_if #(
  parameter int DATA_WIDTH = 25
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/bram_fifo_reader.sv
// ----------------------------------------------------------------------------
// bram_fifo_reader
//   Read-side controller for a flagless dual-port BRAM FIFO. Occupancy is
//   tracked by shadowing the writer's push strobe; fifo_rden is raised only
//   while the BRAM holds unread words and the 2-entry output buffer has room
//   for everything already committed to it. The buffer hides the one-cycle
//   BRAM read latency so the stream runs at one word per cycle.
//
// Ports
//   clk, rst       : clock, asynchronous active-high reset
//   clear_counter  : synchronous clear (only with FIFO_READER_CLEAR_EN)
//   wr_push        : copy of the writer's wren
//   fifo_do        : BRAM read data, valid the cycle after fifo_rden
//   fifo_rden      : BRAM read enable (advances the FIFO read pointer)
//   level          : words in the BRAM not yet read
//   empty          : nothing stored, nothing in flight, buffer empty
//   overflow       : sticky, a push arrived while the BRAM was full
//   strm           : output stream (bram_fifo_reader_if.master)
//
// Build option
//   FIFO_READER_CLEAR_EN : adds clear_counter, which drops all occupancy
//                          state on the next edge and blocks reads/pushes
//                          in the cycle it is high.
// ----------------------------------------------------------------------------
module bram_fifo_reader #(
  parameter int DATA_WIDTH = 25,
  parameter int DEPTH      = 256,
  parameter int LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef FIFO_READER_CLEAR_EN
  input  logic                  clear_counter,
`endif
  input  logic                  wr_push,
  input  logic [DATA_WIDTH-1:0] fifo_do,
  output logic                  fifo_rden,
  output logic [LVL_W-1:0]      level,
  output logic                  empty,
  output logic                  overflow,
  bram_fifo_reader_if.master    strm
);

  logic [LVL_W-1:0]      lvl_q;
  logic                  ovf_q;
  logic                  inflight;
  logic [1:0]            bcnt;
  logic [DATA_WIDTH-1:0] buf0;   // head entry
  logic [DATA_WIDTH-1:0] buf1;
  logic                  clr;
  logic                  pop;
  logic                  rden;
  logic [2:0]            committed;

`ifdef FIFO_READER_CLEAR_EN
  assign clr = clear_counter;
`else
  assign clr = 1'b0;
`endif

  assign pop = (bcnt != 2'd0) && strm.m_ready;

  // Words that will sit in the buffer after this edge, not counting a read
  // issued now. pop implies bcnt>=1, so this never underflows.
  assign committed = {1'b0, bcnt} + {2'b00, inflight} - {2'b00, pop};

  // A read issued now lands in the buffer two edges later; keeping committed
  // below 2 guarantees that word always has a free slot.
  assign rden = !clr && (lvl_q != '0) && (committed < 3'd2);

  // ---------------------------------------------------------------- occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      lvl_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      unique case ({wr_push, rden})
        2'b10: begin
          if (lvl_q == LVL_W'(DEPTH)) ovf_q <= 1'b1;   // push lost
          else                        lvl_q <= lvl_q + LVL_W'(1);
        end
        2'b01:   lvl_q <= lvl_q - LVL_W'(1);
        default: ;                                      // idle, or push+read
      endcase
    end
  end

  // ---------------------------------------------------------- read in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      inflight <= 1'b0;
    else if (clr) inflight <= 1'b0;
    else          inflight <= rden;
  end

  // ------------------------------------------------------------ output buffer
  // buf0 is always the head; a pop shifts buf1 forward, and a word arriving
  // on fifo_do fills the first slot left free after any pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
    end else if (clr) begin
      bcnt <= 2'd0;
    end else begin
      unique case ({inflight, pop})
        2'b10: begin
          if (bcnt == 2'd0) buf0 <= fifo_do;
          else              buf1 <= fifo_do;
          bcnt <= bcnt + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          bcnt <= bcnt - 2'd1;
        end
        2'b11: begin
          if (bcnt == 2'd2) begin
            buf0 <= buf1;
            buf1 <= fifo_do;
          end else begin
            buf0 <= fifo_do;
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------ outputs
  assign fifo_rden    = rden;
  assign level        = lvl_q;
  assign overflow     = ovf_q;
  assign empty        = (lvl_q == '0) && !inflight && (bcnt == 2'd0);
  assign strm.m_data  = buf0;
  assign strm.m_valid = (bcnt != 2'd0);

endmodule

// File: tb/tb_bram_fifo_reader.sv
module tb_bram_fifo_reader;
  localparam int DW    = 25;
  localparam int DEPTH = 256;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_push;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] fifo_do;
  logic          fifo_rden;
  logic [LW-1:0] level;
  logic          empty;
  logic          overflow;
  logic          clr_in;

  bram_fifo_reader_if #(.DATA_WIDTH(DW)) strm ();

  bram_fifo_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
`ifdef FIFO_READER_CLEAR_EN
    .clear_counter(clr_in),
`endif
    .wr_push(wr_push),
    .fifo_do(fifo_do),
    .fifo_rden(fifo_rden),
    .level(level),
    .empty(empty),
    .overflow(overflow),
    .strm(strm)
  );

  always #5 clk = ~clk;

  // Flagless BRAM FIFO: a push is readable from the next cycle, DO updates
  // the edge after rden, a push into a full memory is lost.
  logic [DW-1:0] bram_q[$];
  int            bram_err = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_q.delete();
      fifo_do <= '0;
    end else if (clr_in) begin
      bram_q.delete();
    end else begin
      if (fifo_rden) begin
        if (bram_q.size() == 0) bram_err <= bram_err + 1;
        else                    fifo_do  <= bram_q.pop_front();
      end
      if (wr_push && bram_q.size() < DEPTH) bram_q.push_back(wr_data);
    end
  end

  // Reference: words accepted and not yet delivered, in order.
  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_w, prev_data, s_data, last_data;
  logic          ovf_model, prev_hold;
  logic          s_rden, s_valid, s_empty, s_ovf, s_ready;
  logic [LW-1:0] s_level;
  int            n_cmp = 0, n_bad = 0;
  int            cyc = 0, nx = 0, first_x = 0, last_x = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, score transfers, account pushes.
  task automatic step();
    @(negedge clk);
    s_rden  = fifo_rden;   s_valid = strm.m_valid; s_data = strm.m_data;
    s_level = level;       s_empty = empty;        s_ovf  = overflow;
    s_ready = strm.m_ready;
    if (prev_hold) begin
      chk("hold_valid", 64'(s_valid), 64'(1));
      chk("hold_data", 64'(s_data), 64'(prev_data));
    end
    if (s_valid && s_ready) begin
      chk("xfer_expected", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        chk("xfer_data", 64'(s_data), 64'(exp_w));
      end
      if (nx == 0) first_x = cyc;
      last_x = cyc;
      nx++;
      last_data = s_data;
    end
    prev_hold = s_valid && !s_ready;
    prev_data = s_data;
    // Reader can hold DEPTH in BRAM plus 2 buffered; beyond that a push is lost.
    if (wr_push && !clr_in) begin
      if (sb.size() >= DEPTH + 2) ovf_model = 1'b1;
      else                        sb.push_back(wr_data);
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drain(input string tag, input int bound);
    for (int k = 0; k < bound && sb.size() != 0; k++) step();
    chk(tag, 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; wr_push = 1'b0; wr_data = '0; strm.m_ready = 1'b0; clr_in = 1'b0;
    ovf_model = 1'b0; prev_hold = 1'b0; prev_data = '0; last_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rden", 64'(fifo_rden), 64'(0));
    chk("rst_valid", 64'(strm.m_valid), 64'(0));
    chk("rst_data", 64'(strm.m_data), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_ovf", 64'(overflow), 64'(0));
    rst = 1'b0;

    // Single word latency: rden in cycle 1, m_valid only in cycle 3.
    strm.m_ready = 1'b1;
    wr_push = 1'b1; wr_data = 25'h1ABCDEF; step();
    chk("sw_c0_valid", 64'(s_valid), 64'(0));
    wr_push = 1'b0; step();
    chk("sw_c1_level", 64'(s_level), 64'(1));
    chk("sw_c1_rden", 64'(s_rden), 64'(1));
    chk("sw_c1_valid", 64'(s_valid), 64'(0));
    step();
    chk("sw_c2_valid", 64'(s_valid), 64'(0));
    step();
    chk("sw_c3_valid", 64'(s_valid), 64'(1));
    chk("sw_c3_data", 64'(s_data), 64'(25'h1ABCDEF));
    step();
    chk("sw_c4_valid", 64'(s_valid), 64'(0));
    chk("sw_c4_level", 64'(s_level), 64'(0));
    chk("sw_c4_empty", 64'(s_empty), 64'(1));

    // Full-rate stream of 300 words.
    nx = 0;
    for (int i = 0; i < 300; i++) begin
      wr_push = 1'b1; wr_data = DW'(i); step();
    end
    wr_push = 1'b0;
    drain("stream_drain", 50);
    chk("stream_count", 64'(nx), 64'(300));
    chk("stream_back_to_back", 64'(last_x - first_x), 64'(299));
    step();
    chk("stream_empty", 64'(s_empty), 64'(1));

    // Backpressure: 10 words with the consumer stalled.
    strm.m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_push = 1'b1; wr_data = DW'(12'h100 + i); step();
    end
    wr_push = 1'b0;
    repeat (3) step();
    chk("bp_level", 64'(s_level), 64'(8));
    chk("bp_rden", 64'(s_rden), 64'(0));
    chk("bp_valid", 64'(s_valid), 64'(1));
    chk("bp_bcnt", 64'(dut.bcnt), 64'(2));
    strm.m_ready = 1'b1; nx = 0;
    step();
    chk("bp_resume_rden", 64'(s_rden), 64'(1));
    drain("bp_drain", 40);
    chk("bp_count", 64'(nx), 64'(10));
    step();
    chk("bp_empty", 64'(s_empty), 64'(1));

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      strm.m_ready = ($urandom % 10) < 7;
      wr_push      = ($urandom % 10) < 4;
      wr_data      = DW'($urandom);
      step();
    end
    wr_push = 1'b0; strm.m_ready = 1'b1;
    drain("rnd_drain", 400);
    step();
    chk("rnd_empty", 64'(s_empty), 64'(1));
    chk("rnd_level", 64'(s_level), 64'(0));
    chk("rnd_ovf", 64'(s_ovf), 64'(ovf_model));

    // Overflow: 259 pushes into a stalled reader; the last one is lost.
    strm.m_ready = 1'b0;
    for (int i = 0; i < 259; i++) begin
      wr_push = 1'b1; wr_data = DW'(20'h20000 + i); step();
    end
    wr_push = 1'b0;
    step();
    chk("ovf_level", 64'(s_level), 64'(DEPTH));
    chk("ovf_flag", 64'(s_ovf), 64'(ovf_model));
    chk("ovf_model_set", 64'(ovf_model), 64'(1));
    strm.m_ready = 1'b1; nx = 0;
    drain("ovf_drain", 400);
    chk("ovf_count", 64'(nx), 64'(258));
    step();
    chk("ovf_sticky", 64'(s_ovf), 64'(1));

    // Asynchronous reset in the middle of a transfer.
    for (int i = 0; i < 4; i++) begin
      wr_push = 1'b1; wr_data = DW'(i + 7); step();
    end
    #3 rst = 1'b1; wr_push = 1'b0;
    #1;
    chk("arst_rden", 64'(fifo_rden), 64'(0));
    chk("arst_valid", 64'(strm.m_valid), 64'(0));
    chk("arst_data", 64'(strm.m_data), 64'(0));
    chk("arst_level", 64'(level), 64'(0));
    chk("arst_empty", 64'(empty), 64'(1));
    chk("arst_ovf", 64'(overflow), 64'(0));
    sb.delete(); ovf_model = 1'b0; prev_hold = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

`ifdef FIFO_READER_CLEAR_EN
    // Synchronous clear with 5 words stored.
    strm.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_push = 1'b1; wr_data = DW'(i + 40); step();
    end
    wr_push = 1'b0;
    step();
    clr_in = 1'b1; step();
    chk("clr_rden", 64'(s_rden), 64'(0));
    clr_in = 1'b0; sb.delete(); prev_hold = 1'b0;
    step();
    chk("clr_level", 64'(s_level), 64'(0));
    chk("clr_valid", 64'(s_valid), 64'(0));
    chk("clr_empty", 64'(s_empty), 64'(1));
    strm.m_ready = 1'b1;
    wr_push = 1'b1; wr_data = DW'(8'h55); step();
    wr_push = 1'b0;
    drain("clr_drain", 20);
    chk("clr_data", 64'(last_data), 64'(8'h55));
`endif

    // Sanity after reset: a short burst still flows in order.
    strm.m_ready = 1'b1; nx = 0;
    for (int i = 0; i < 6; i++) begin
      wr_push = 1'b1; wr_data = DW'($urandom); step();
    end
    wr_push = 1'b0;
    drain("post_drain", 30);
    chk("post_count", 64'(nx), 64'(6));
    step();
    chk("post_empty", 64'(s_empty), 64'(1));
    chk("bram_no_empty_read", 64'(bram_err), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
